// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 serial transmitter timed by a 16x oversampling tick.
module uart_transmitter #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       s_tick,
    input  logic       tx_start,
    input  logic [7:0] tx_din,
    output logic       tx,
    output logic       tx_reg,
    output logic       tx_done_tick
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;
    logic [1:0]    state_q, state_d;
    logic [3:0]    s_q, s_d;
    logic [NW-1:0] n_q, n_d;
    logic [7:0]    b_q, b_d;
    logic          tx_q, tx_d;
    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        n_d          = n_q;
        b_d          = b_q;
        tx_done_tick = 1'b0;
        tx_d         = (state_q == DATA) ? b_q[0] : (state_q != START);
        case (state_q)
            IDLE: if (tx_start) begin
                s_d     = 4'd0;
                b_d     = tx_din;
                state_d = START;
            end
            START: if (s_tick) begin
                if (s_q == 4'd15) begin
                    s_d     = 4'd0;
                    n_d     = '0;
                    state_d = DATA;
                end else s_d = s_q + 4'd1;
            end
            DATA: if (s_tick) begin
                if (s_q == 4'd15) begin
                    s_d = 4'd0;
                    b_d = b_q >> 1;
                    if (n_q == NW'(DBIT - 1)) state_d = STOP;
                    else n_d = n_q + 1'b1;
                end else s_d = s_q + 4'd1;
            end
            default: if (s_tick) begin
                if (s_q == 4'(SB_TICK - 1)) begin
                    // reset wins over a coincident end-of-stop so no pulse escapes
                    tx_done_tick = !reset_n;
                    state_d      = IDLE;
                end else s_d = s_q + 4'd1;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (reset_n) begin
            state_q <= IDLE;
            s_q     <= 4'd0;
            n_q     <= '0;
            b_q     <= 8'd0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            s_q     <= s_d;
            n_q     <= n_d;
            b_q     <= b_d;
            tx_q    <= tx_d;
        end
    end
    assign tx     = tx_q;
    assign tx_reg = tx_q;
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: random and directed frames checked against a tick-count frame model.
module tb_uart_transmitter;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b1;
    logic       start = 1'b0;
    logic [7:0] din = 8'd0;
    logic       tx, tx_reg, done;
    int         checks = 0;
    int         failures = 0;
    int         done_cnt = 0;
    int         mode = 0;
    int         tcnt = 0;
    bit         chk_en = 1'b0;
    uart_transmitter dut (
        .clk(clk), .reset_n(rst), .s_tick(tick), .tx_start(start),
        .tx_din(din), .tx(tx), .tx_reg(tx_reg), .tx_done_tick(done)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask
    // frame model: position in the frame is just the number of ticks seen since acceptance
    bit         m_busy = 1'b0;
    int         m_ticks = 0;
    logic [7:0] m_byte = 8'd0;
    logic       m_tx = 1'b1;
    function automatic logic line_of(input int t, input logic [7:0] by);
        int k;
        k = t / 16;
        return (k == 0) ? 1'b0 : (k <= 8) ? by[k-1] : 1'b1;
    endfunction
    always @(posedge clk) begin
        logic ln;
        ln = m_busy ? line_of(m_ticks, m_byte) : 1'b1;
        if (rst) begin
            m_busy  = 1'b0;
            m_ticks = 0;
            m_tx    = 1'b1;
        end else begin
            m_tx = ln;
            if (!m_busy) begin
                if (start) begin
                    m_busy  = 1'b1;
                    m_byte  = din;
                    m_ticks = 0;
                end
            end else if (tick) begin
                m_ticks++;
                if (m_ticks == 160) m_busy = 1'b0;
            end
        end
    end
    always @(negedge clk) begin
        if (chk_en) begin
            chk("tx", 32'(tx), 32'(m_tx));
            chk("tx_reg", 32'(tx_reg), 32'(m_tx));
            chk("done", 32'(done), 32'(!rst && m_busy && tick && m_ticks == 159));
            if (done) done_cnt++;
        end
    end
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            case (mode)
                1: tick = (tcnt % 4 == 0);
                2: begin
                    tick  = 1'($urandom_range(0, 1));
                    start = ($urandom_range(0, 15) == 0);
                    din   = 8'($urandom);
                end
                default: tick = 1'b1;
            endcase
            tcnt++;
        end
    endtask
    task automatic pulse(input logic [7:0] v);
        din   = v;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask
    initial begin
        rst = 1'b1;
        cyc(1);
        chk_en = 1'b1;
        cyc(1);
        chk("rst_tx", 32'(tx), 32'd1);
        chk("rst_tx_reg", 32'(tx_reg), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        rst = 1'b0;
        cyc(3);
        done_cnt = 0;
        pulse(8'h36);
        cyc(170);
        chk("single_done_cnt", 32'(done_cnt), 32'd1);
        done_cnt = 0;
        din = 8'h36;
        start = 1'b1;
        cyc(330);
        start = 1'b0;
        cyc(170);
        chk("b2b_done_cnt", 32'(done_cnt), 32'd3);
        done_cnt = 0;
        pulse(8'hA5);
        cyc(40);
        din = 8'hFF;
        cyc(140);
        chk("midchg_done_cnt", 32'(done_cnt), 32'd1);
        mode = 1;
        tcnt = 0;
        done_cnt = 0;
        pulse(8'h01);
        cyc(700);
        chk("sparse_done_cnt", 32'(done_cnt), 32'd1);
        mode = 0;
        done_cnt = 0;
        pulse(8'hC3);
        cyc(16 + 16 * 3 + 6);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("abort_tx", 32'(tx), 32'd1);
        chk("abort_done_cnt", 32'(done_cnt), 32'd0);
        cyc(2);
        pulse(8'h5A);
        cyc(170);
        chk("after_abort_done_cnt", 32'(done_cnt), 32'd1);
        mode = 2;
        cyc(3000);
        mode = 0;
        start = 1'b0;
        cyc(200);
        chk("final_idle_tx", 32'(tx), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
